// File: rtl/qam_seq_pkg.sv
// qam_seq_pkg: shared definitions for the 16-QAM frame sequencer.
//   seq_state_t       - sequencer state; names what is loaded next
//   PRE_SYM_EVEN/ODD  - alternating preamble symbol indices
//   PILOT_SYM_DEFAULT - default pilot symbol index
//   preamble_sym()    - preamble symbol for a given preamble position
package qam_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        HI    = 3'd2,
        LO    = 3'd3,
        PILOT = 3'd4
    } seq_state_t;

    localparam logic [3:0] PRE_SYM_EVEN      = 4'b0000;
    localparam logic [3:0] PRE_SYM_ODD       = 4'b1111;
    localparam logic [3:0] PILOT_SYM_DEFAULT = 4'b1101;

    // Preamble alternates 0000 / 1111 starting with 0000 at position 0.
    function automatic logic [3:0] preamble_sym(input logic [7:0] idx);
        return idx[0] ? PRE_SYM_ODD : PRE_SYM_EVEN;
    endfunction

endpackage

// File: rtl/qam_frame_sequencer.sv
// qam_frame_sequencer: turns a byte stream into 4-bit 16-QAM symbol indices
// (high nibble first), prepends an alternating preamble to every frame and,
// when QAM_SEQ_PILOT_EN is defined, inserts a pilot symbol after every
// PILOT_PERIOD payload symbols (never after the final symbol of a frame).
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   s_data/s_valid/s_last/s_ready - byte source (s_ready only high in HI)
//   m_data/m_valid/m_last/m_ready - symbol stream to the mapper
//   busy              - frame in progress or output register occupied
//   frame_cnt         - number of completed frames (wraps)
//
// Macro QAM_SEQ_PILOT_EN: enables pilot insertion. Without it the PILOT
// state and the payload symbol counter are absent and PILOT_PERIOD /
// PILOT_SYM have no effect.
module qam_frame_sequencer
    import qam_seq_pkg::*;
#(
    parameter int         PREAMBLE_LEN = 8,
    parameter int         PILOT_PERIOD = 16,
    parameter logic [3:0] PILOT_SYM    = PILOT_SYM_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [3:0]  m_data,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN - 1);

    seq_state_t state_r;
    logic [7:0] pre_idx_r;
    logic [3:0] lo_r;
    logic       last_r;
    logic       slot_free_s;

`ifdef QAM_SEQ_PILOT_EN
    localparam logic [7:0] PERIOD = 8'(PILOT_PERIOD);

    logic [7:0] sym_cnt_r;
    logic       ret_lo_r;     // state to resume after the pilot: 1 = LO, 0 = HI
    logic [7:0] sym_next_s;
    logic       pilot_due_s;

    assign sym_next_s  = sym_cnt_r + 8'd1;
    assign pilot_due_s = (sym_next_s == PERIOD);
`else
    // Pilot configuration is not used when pilots are compiled out.
    logic unused_pilot_cfg_s;
    assign unused_pilot_cfg_s = ^{PILOT_SYM, 8'(PILOT_PERIOD)};
`endif

    // The output register may take a new symbol when empty or being drained.
    assign slot_free_s = !m_valid || m_ready;
    assign s_ready     = (state_r == HI) && slot_free_s;
    assign busy        = (state_r != IDLE) || m_valid;

    // Sequencer state, output register and frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            pre_idx_r <= 8'd0;
            lo_r      <= 4'h0;
            last_r    <= 1'b0;
            m_data    <= 4'h0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            frame_cnt <= 16'd0;
`ifdef QAM_SEQ_PILOT_EN
            sym_cnt_r <= 8'd0;
            ret_lo_r  <= 1'b0;
`endif
        end else begin
            if (m_valid && m_ready && m_last) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (slot_free_s) begin
                // Empty unless one of the branches below loads a symbol.
                m_valid <= 1'b0;
                case (state_r)
                    IDLE: begin
                        // Frame start; the first byte stays at the source.
                        if (s_valid) begin
                            m_data    <= PRE_SYM_EVEN;
                            m_valid   <= 1'b1;
                            m_last    <= 1'b0;
                            pre_idx_r <= 8'd1;
                            state_r   <= (PREAMBLE_LEN == 1) ? HI : PRE;
`ifdef QAM_SEQ_PILOT_EN
                            sym_cnt_r <= 8'd0;
`endif
                        end
                    end
                    PRE: begin
                        m_data    <= preamble_sym(pre_idx_r);
                        m_valid   <= 1'b1;
                        m_last    <= 1'b0;
                        pre_idx_r <= pre_idx_r + 8'd1;
                        if (pre_idx_r == PRE_LAST) begin
                            state_r <= HI;
                        end
                    end
                    HI: begin
                        if (s_valid) begin
                            m_data  <= s_data[7:4];
                            m_valid <= 1'b1;
                            m_last  <= 1'b0;
                            lo_r    <= s_data[3:0];
                            last_r  <= s_last;
`ifdef QAM_SEQ_PILOT_EN
                            sym_cnt_r <= sym_next_s;
                            if (pilot_due_s) begin
                                state_r  <= PILOT;
                                ret_lo_r <= 1'b1;
                            end else begin
                                state_r <= LO;
                            end
`else
                            state_r <= LO;
`endif
                        end
                    end
                    LO: begin
                        m_data  <= lo_r;
                        m_valid <= 1'b1;
                        m_last  <= last_r;
                        if (last_r) begin
                            // No pilot after the final symbol of a frame.
                            state_r <= IDLE;
`ifdef QAM_SEQ_PILOT_EN
                            sym_cnt_r <= 8'd0;
`endif
                        end else begin
`ifdef QAM_SEQ_PILOT_EN
                            sym_cnt_r <= sym_next_s;
                            if (pilot_due_s) begin
                                state_r  <= PILOT;
                                ret_lo_r <= 1'b0;
                            end else begin
                                state_r <= HI;
                            end
`else
                            state_r <= HI;
`endif
                        end
                    end
`ifdef QAM_SEQ_PILOT_EN
                    PILOT: begin
                        m_data    <= PILOT_SYM;
                        m_valid   <= 1'b1;
                        m_last    <= 1'b0;
                        sym_cnt_r <= 8'd0;
                        state_r   <= ret_lo_r ? LO : HI;
                    end
`endif
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qam_frame_sequencer.sv
// Self-checking bench for qam_frame_sequencer. A frame-level model turns each
// submitted frame into its expected symbol list (preamble, nibbles, pilots);
// one compare process checks every output handshake, hold behaviour under
// backpressure and frame_cnt. A second instance with PREAMBLE_LEN=1 covers
// back-to-back frames.
module tb_qam_frame_sequencer;

    localparam int         P_PRE  = 4;
    localparam int         P_PER  = 4;
    localparam logic [3:0] P_PSYM = 4'b1101;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [7:0]  s_data;
    logic        s_valid, s_last, s_ready;
    logic [3:0]  m_data;
    logic        m_valid, m_last, m_ready, busy;
    logic [15:0] frame_cnt;

    logic [7:0]  s1_data;
    logic        s1_valid, s1_last, s1_ready;
    logic [3:0]  m1_data;
    logic        m1_valid, m1_last, m1_ready, busy1;
    logic [15:0] frame_cnt1;

    qam_frame_sequencer #(.PREAMBLE_LEN(P_PRE), .PILOT_PERIOD(P_PER), .PILOT_SYM(P_PSYM)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
        .m_ready(m_ready), .busy(busy), .frame_cnt(frame_cnt));

    qam_frame_sequencer #(.PREAMBLE_LEN(1), .PILOT_PERIOD(P_PER), .PILOT_SYM(P_PSYM)) dut1 (
        .clk(clk), .rst(rst), .s_data(s1_data), .s_valid(s1_valid), .s_last(s1_last),
        .s_ready(s1_ready), .m_data(m1_data), .m_valid(m1_valid), .m_last(m1_last),
        .m_ready(m1_ready), .busy(busy1), .frame_cnt(frame_cnt1));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [4:0] exp_q[$];   // {last, symbol}
    logic [8:0] src_q[$];   // {last, byte}
    logic [4:0] log_q[$];
    int         log_cyc[$];
    int         src_idx = 0;
    int         fc_model = 0;
    bit         chk_en = 1'b0;
    bit         stall_prev = 1'b0;
    logic [4:0] prev_sym = 5'h00;
    bit         rand_valid = 1'b0;
    bit         rand_ready = 1'b0;
    bit         bp_arm = 1'b0;
    int         bp_cnt = 0;
    int         bp_seen = 0;
    int         start_cyc = -1;
    int         first_acc_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame model: preamble, then nibbles high-first, a pilot after every
    // P_PER payload symbols unless that symbol ends the frame.
    function automatic void push_frame(input logic [7:0] b[$]);
        int         n;
        logic [7:0] bv;
        logic [3:0] nib;
        n = b.size();
        for (int i = 0; i < P_PRE; i++)
            exp_q.push_back({1'b0, (i % 2 == 1) ? 4'hF : 4'h0});
        for (int j = 0; j < 2 * n; j++) begin
            bv  = b[j / 2];
            nib = (j % 2 == 0) ? bv[7:4] : bv[3:0];
            exp_q.push_back({(j == 2 * n - 1), nib});
`ifdef QAM_SEQ_PILOT_EN
            if (j != 2 * n - 1 && (j + 1) % P_PER == 0)
                exp_q.push_back({1'b0, P_PSYM});
`endif
        end
        for (int i = 0; i < n; i++)
            src_q.push_back({(i == n - 1), b[i]});
    endfunction

    // Compare process: every output handshake, hold under stall, frame_cnt.
    always @(negedge clk) begin
        logic [4:0] e;
        #2;
        if (chk_en) begin
            check("frame_cnt", 32'(frame_cnt), fc_model);
            if (m_valid) check("busy_valid", 32'(busy), 32'd1);
            if (stall_prev) begin
                check("hold_valid", 32'(m_valid), 32'd1);
                check("hold_sym", 32'({m_last, m_data}), 32'(prev_sym));
            end
            if (m_valid && m_ready) begin
                log_q.push_back({m_last, m_data});
                log_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("extra_sym", 32'({m_last, m_data}), 32'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("sym", 32'({m_last, m_data}), 32'(e));
                    if (e[4]) fc_model++;
                end
            end
            stall_prev = m_valid && !m_ready;
            prev_sym   = {m_last, m_data};
        end
    end

    task automatic step();
        bit hold;
        @(negedge clk);
        if (src_idx < src_q.size() && (!rand_valid || $urandom_range(3) != 0)) begin
            s_valid = 1'b1;
            {s_last, s_data} = src_q[src_idx];
            if (start_cyc < 0) start_cyc = cyc;
        end else begin
            s_valid = 1'b0;
            s_last  = 1'b0;
            s_data  = 8'h00;
        end
        if (bp_arm && m_valid && m_data == 4'h1) begin
            bp_cnt = 3;
            bp_arm = 1'b0;
        end
        hold = (bp_cnt > 0);
        if (hold) begin
            m_ready = 1'b0;
            bp_cnt--;
            bp_seen++;
        end else begin
            m_ready = rand_ready ? ($urandom_range(3) != 0) : 1'b1;
        end
        #1;
        if (hold) begin
            check("bp_s_ready", 32'(s_ready), 32'd0);
            check("bp_m_data", 32'(m_data), 32'h1);
            check("bp_m_valid", 32'(m_valid), 32'd1);
        end
        if (s_valid && s_ready) begin
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            src_idx++;
        end
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        while ((src_idx < src_q.size() || exp_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        check({"drain_", name}, 32'(exp_q.size() + src_q.size() - src_idx), 32'd0);
        step();
        step();
    endtask

    task automatic new_scenario();
        log_q.delete();
        log_cyc.delete();
        start_cyc     = -1;
        first_acc_cyc = -1;
    endtask

    task automatic reset_dut(input string name);
        chk_en = 1'b0;
        @(negedge clk);
        rst      = 1'b1;
        s_valid  = 1'b0;
        m_ready  = 1'b1;
        s1_valid = 1'b0;
        @(negedge clk);
        #1;
        check({name, "_s_ready"}, 32'(s_ready), 32'd0);
        check({name, "_m_valid"}, 32'(m_valid), 32'd0);
        check({name, "_m_last"}, 32'(m_last), 32'd0);
        check({name, "_m_data"}, 32'(m_data), 32'h0);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        src_q.delete();
        src_idx    = 0;
        fc_model   = 0;
        stall_prev = 1'b0;
        chk_en     = 1'b1;
    endtask

    initial begin
        logic [7:0] bq[$];
        logic [4:0] lit_ab[8];
`ifdef QAM_SEQ_PILOT_EN
        logic [3:0] lit_pil[11];
`else
        logic [3:0] lit_pil[10];
`endif
        logic [4:0] b2b[6];
        int idx;
        int want;

        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; m_ready = 1'b1;
        s1_valid = 1'b0; s1_last = 1'b0; s1_data = 8'h00; m1_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset_dut("reset");

        // Two-byte frame, full throughput.
        new_scenario();
        bq.delete(); bq.push_back(8'hA5); bq.push_back(8'h3C);
        push_frame(bq);
        drain(100, "two_byte");
        lit_ab = '{5'h00, 5'h0F, 5'h00, 5'h0F, 5'h0A, 5'h05, 5'h03, 5'h1C};
        check("ab_count", 32'(log_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < log_q.size(); i++)
            check("ab_sym", 32'(log_q[i]), 32'(lit_ab[i]));
        check("first_latency", log_cyc[0] - start_cyc, 32'd1);
        check("no_bubbles", log_cyc[7] - log_cyc[0], 32'd7);
        check("first_accept", first_acc_cyc - start_cyc, P_PRE);
        check("ab_frame_cnt", 32'(frame_cnt), 32'd1);
        check("ab_idle_busy", 32'(busy), 32'd0);

        // Pilot insertion with 3 cycles of backpressure on nibble 1.
        new_scenario();
        bq.delete(); bq.push_back(8'h12); bq.push_back(8'h34); bq.push_back(8'h56);
        push_frame(bq);
`ifdef QAM_SEQ_PILOT_EN
        lit_pil = '{4'h0, 4'hF, 4'h0, 4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 4'hD, 4'h5, 4'h6};
`else
        lit_pil = '{4'h0, 4'hF, 4'h0, 4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
`endif
        check("model_len", 32'(exp_q.size()), 32'($size(lit_pil)));
        for (int i = 0; i < $size(lit_pil) && i < exp_q.size(); i++)
            check("model_pin", 32'(exp_q[i]), 32'({(i == $size(lit_pil) - 1), lit_pil[i]}));
        bp_arm = 1'b1;
        drain(100, "pilot");
        check("bp_cycles", bp_seen, 32'd3);
        check("pil_count", 32'(log_q.size()), 32'($size(lit_pil)));
        for (int i = 0; i < $size(lit_pil) && i < log_q.size(); i++)
            check("pil_sym", 32'(log_q[i][3:0]), 32'(lit_pil[i]));
        check("pil_frame_cnt", 32'(frame_cnt), 32'd2);

        // Randomised frames with random source gaps and mapper stalls.
        new_scenario();
        rand_valid = 1'b1;
        rand_ready = 1'b1;
        for (int f = 0; f < 20; f++) begin
            bq.delete();
            for (int k = 0; k < int'($urandom_range(6, 1)); k++)
                bq.push_back(8'($urandom));
            push_frame(bq);
        end
        drain(6000, "random");
        check("rand_frame_cnt", 32'(frame_cnt), 32'd22);
        rand_valid = 1'b0;
        rand_ready = 1'b0;

        // Reset after the second payload symbol, then a fresh frame.
        new_scenario();
        bq.delete(); bq.push_back(8'hC3); bq.push_back(8'h5A); bq.push_back(8'h77);
        push_frame(bq);
        want = P_PRE + 2;
        for (int n = 0; n < 40 && log_q.size() < want; n++) step();
        check("mid_progress", 32'(log_q.size() >= want), 32'd1);
        reset_dut("midreset");
        new_scenario();
        bq.delete(); bq.push_back(8'h9A);
        push_frame(bq);
        drain(100, "after_reset");
        check("restart_count", 32'(log_q.size()), 32'(P_PRE + 2));
        if (log_q.size() > 0) check("restart_first", 32'(log_q[0]), 32'h00);
        check("restart_frame_cnt", 32'(frame_cnt), 32'd1);

        // Back-to-back single-byte frames on the PREAMBLE_LEN=1 instance.
        b2b = '{5'h00, 5'h07, 5'h17, 5'h00, 5'h08, 5'h18};
        idx = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (idx == 0) begin
                s1_valid = 1'b1; s1_data = 8'h77; s1_last = 1'b1;
            end else if (idx == 1) begin
                s1_valid = 1'b1; s1_data = 8'h88; s1_last = 1'b1;
            end else begin
                s1_valid = 1'b0; s1_data = 8'h00; s1_last = 1'b0;
            end
            #1;
            if (k >= 1 && k <= 6) begin
                check("b2b_valid", 32'(m1_valid), 32'd1);
                check("b2b_sym", 32'({m1_last, m1_data}), 32'(b2b[k - 1]));
            end
            if (k == 7) begin
                check("b2b_idle", 32'(m1_valid), 32'd0);
                check("b2b_frame_cnt", 32'(frame_cnt1), 32'd2);
            end
            if (s1_valid && s1_ready) idx++;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/qam_frame_sequencer.md
# qam_frame_sequencer

Frame sequencer that sits directly upstream of the 16-QAM symbol mapper. It converts a byte stream into 4-bit symbol indices and prepends a fixed preamble to every frame. With pilots compiled in, it also inserts a pilot symbol after every PILOT_PERIOD payload symbols. It drives the mapper's valid/ready/last nibble interface and stalls the byte source whenever the mapper withholds ready.

## Interface
- PREAMBLE_LEN, 8: preamble symbols per frame; range 1..255.
- PILOT_PERIOD, 16: payload symbols between pilots; range 1..255.
- PILOT_SYM, 4'b1101: pilot symbol index.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_data  in  8  payload byte; high nibble sent first.
- s_valid  in  1  s_data valid.
- s_last  in  1  byte is the final byte of its frame.
- s_ready  out  1  byte accepted when s_valid && s_ready.
- m_data  out  4  symbol index to the mapper.
- m_valid  out  1  m_data valid.
- m_last  out  1  final symbol of the frame.
- m_ready  in  1  mapper accepts when m_valid && m_ready.
- busy  out  1  high whenever state != IDLE or m_valid=1.
- frame_cnt  out  16  completed frames; wraps 16'hFFFF -> 0.

## Operation
- Output register: m_data, m_valid, m_last. The slot is free when !m_valid || m_ready. The register loads only when the slot is free.
  - If the slot is free and nothing is loaded, m_valid <= 0.
  - While m_valid=1 && !m_ready, m_data and m_last are held stable.
- The state names what is loaded next: IDLE, PRE, HI, LO, PILOT.
- IDLE: on s_valid=1 with slot free, load preamble[0], set pre_idx <= 1, go to PRE (or to HI if PREAMBLE_LEN=1). The byte is not consumed.
- PRE: on slot free, load preamble[pre_idx]. Symbol i is 4'b0000 for even i and 4'b1111 for odd i. After loading index PREAMBLE_LEN-1, go to HI.
- HI: s_ready = slot free.
  - On accept: load s_data[7:4] with m_last=0; capture lo_q <= s_data[3:0] and last_q <= s_last.
  - Increment sym_cnt; go to PILOT if sym_cnt reaches PILOT_PERIOD, else to LO.
- LO: on slot free, load lo_q with m_last=last_q and increment sym_cnt.
  - If last_q: go to IDLE and clear sym_cnt (no trailing pilot).
  - Otherwise go to PILOT if sym_cnt reaches PILOT_PERIOD, else to HI.
- PILOT: on slot free, load PILOT_SYM with m_last=0, clear sym_cnt, and return to the pending state (LO or HI).
- sym_cnt is 8 bits and is cleared at frame start and after every pilot.
- s_ready is 0 in every state except HI.
- frame_cnt increments on each handshake with m_last=1.
- An s_last byte gives a frame of PREAMBLE_LEN + 2·nbytes + pilots symbols.

## Timing
- Reset values: s_ready=0, m_valid=0, m_last=0, m_data=4'h0, busy=0, frame_cnt=0. Internal state: IDLE, counters 0.
- Latency: s_valid rises in IDLE at cycle 0 → preamble[0] presented at cycle 1.
- Back-to-back throughput with m_ready held at 1:
  - One symbol per cycle, with no bubbles between preamble, payload and pilots.
  - One byte accepted every 2 cycles, plus 1 extra cycle per pilot.
- First payload byte accepted in cycle PREAMBLE_LEN (m_ready=1); its high nibble is presented in cycle PREAMBLE_LEN+1.
- Reset mid-frame: the partial frame is discarded and the held byte is not re-emitted. The byte source must restart the frame.
- PILOT_PERIOD=1: a pilot follows every payload symbol except the last.
- A new frame's preamble may be loaded in the same cycle the previous m_last handshakes; there is no idle gap.

## Configuration
- QAM_SEQ_PILOT_EN defined: pilot insertion is as described above.
- QAM_SEQ_PILOT_EN undefined:
  - The PILOT state and sym_cnt are removed.
  - PILOT_PERIOD and PILOT_SYM are ignored.
  - Symbol count per frame is PREAMBLE_LEN + 2·nbytes.

## Structure
- Package qam_seq_pkg holds:
  - the state enum (IDLE, PRE, HI, LO, PILOT);
  - constants PRE_SYM_EVEN=4'b0000, PRE_SYM_ODD=4'b1111 and PILOT_SYM_DEFAULT=4'b1101.
- Single module. The output register slice is small enough to stay inline; there is no sub-module.

## Test plan
- Two-byte frame: PREAMBLE_LEN=4, PILOT_PERIOD=4, bytes 0xA5, 0x3C(last), m_ready=1 → m_data 0,F,0,F,A,5,3,C with m_last on C, no pilot, frame_cnt=1.
- Pilot insertion: same parameters, bytes 0x12, 0x34, 0x56(last) → 0,F,0,F,1,2,3,4,D,5,6 with m_last on 6.
- Backpressure: drop m_ready for 3 cycles while the high nibble 1 is presented → m_data stays 1 and m_valid stays 1 for 3 cycles, s_ready=0, then the stream resumes without loss or duplication.
- Reset mid-frame: assert rst after the second payload symbol → next cycle all outputs equal their reset values and busy=0. A new frame then starts with preamble 0.
- Macro off: build without QAM_SEQ_PILOT_EN and rerun the pilot-insertion scenario → 0,F,0,F,1,2,3,4,5,6 with no D.
- Back-to-back frames: two single-byte frames 0x77(last) and 0x88(last), PREAMBLE_LEN=1 → 0,7,7,0,8,8 in 6 consecutive cycles, frame_cnt=2.
